id_operand_stage: RTL

ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

---
 rtl/id_operand_stage.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/id_operand_stage.sv
// Decode-to-execute operand stage: resolves both source operands through the
// forwarding network, detects load-use hazards and holds the result in a skid-free output register.
module id_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_FWD = 2
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_pc,
    input  logic [7:0]                  in_aluop,
    input  logic [2:0]                  in_alusel,
    input  logic [ADDR_W-1:0]           in_wd,
    input  logic                        in_wreg,
    input  logic [DATA_W-1:0]           in_imm,
    input  logic [ADDR_W-1:0]           in_rs_addr,
    input  logic [ADDR_W-1:0]           in_rt_addr,
    input  logic                        in_rs_rd,
    input  logic                        in_rt_rd,
    input  logic [1:0]                  in_cond,

    output logic                        rf_re1,
    output logic                        rf_re2,
    output logic [ADDR_W-1:0]           rf_raddr1,
    output logic [ADDR_W-1:0]           rf_raddr2,
    input  logic [DATA_W-1:0]           rf_rdata1,
    input  logic [DATA_W-1:0]           rf_rdata2,

    input  logic [NUM_FWD-1:0]          fwd_wreg,
    input  logic [NUM_FWD*ADDR_W-1:0]   fwd_wd,
    input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata,
    input  logic [NUM_FWD-1:0]          fwd_pending,

    input  logic                        flush,

    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_pc,
    output logic [7:0]                  out_aluop,
    output logic [2:0]                  out_alusel,
    output logic [DATA_W-1:0]           out_reg1,
    output logic [DATA_W-1:0]           out_reg2,
    output logic [ADDR_W-1:0]           out_wd,
    output logic                        out_wreg,

    output logic                        stall,
    output logic [15:0]                 stall_cnt
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [31:0]            r_pc;
    logic [7:0]             r_aluop;
    logic [2:0]             r_alusel;
    logic [DATA_W-1:0]      r_reg1;
    logic [DATA_W-1:0]      r_reg2;
    logic [ADDR_W-1:0]      r_wd;
    logic                   r_wreg;
    logic [15:0]            r_stall_cnt;

    logic [ADDR_W-1:0]      w_fwd_wd   [NUM_FWD];
    logic [DATA_W-1:0]      w_fwd_data [NUM_FWD];

    logic [ADDR_W-1:0]      w_port_addr [2];
    logic                   w_port_re   [2];
    logic [DATA_W-1:0]      w_port_rf   [2];

    logic [DATA_W-1:0]      w_reg1;
    logic [DATA_W-1:0]      w_reg2;
    logic                   w_pend1;
    logic                   w_pend2;
    logic                   w_stall;
    logic                   w_in_ready;
    logic                   w_xfer;
    logic                   w_wreg_eff;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_FWD; gi++) begin : g_fwd
            assign w_fwd_wd[gi]   = fwd_wd[gi*ADDR_W +: ADDR_W];
            assign w_fwd_data[gi] = fwd_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_port_addr[0] = in_rs_addr;
    assign w_port_addr[1] = in_rt_addr;
    assign w_port_re[0]   = in_rs_rd;
    assign w_port_re[1]   = in_rt_rd;
    assign w_port_rf[0]   = rf_rdata1;
    assign w_port_rf[1]   = rf_rdata2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic                w_hit;
            logic [DATA_W-1:0]   w_fdata;
            logic                w_fpend;
            logic [DATA_W-1:0]   w_opnd;
            logic                w_pend;

            // Scan oldest to youngest so the youngest matching source wins.
            always_comb begin
                w_hit   = 1'b0;
                w_fdata = '0;
                w_fpend = 1'b0;
                for (int k = NUM_FWD - 1; k >= 0; k--) begin
                    if (fwd_wreg[k] && (w_fwd_wd[k] == w_port_addr[gi])) begin
                        w_hit   = 1'b1;
                        w_fdata = w_fwd_data[k];
                        w_fpend = fwd_pending[k];
                    end
                end
            end

            // Register 0 is hardwired to zero and must never pick up a forward.
            always_comb begin
                w_opnd = w_port_rf[gi];
                w_pend = 1'b0;
                if (!w_port_re[gi]) begin
                    w_opnd = in_imm;
                end else if (w_port_addr[gi] == '0) begin
                    w_opnd = '0;
                end else if (w_hit) begin
                    w_opnd = w_fdata;
                    w_pend = w_fpend;
                end
            end
        end
    endgenerate

    assign w_reg1  = g_port[0].w_opnd;
    assign w_reg2  = g_port[1].w_opnd;
    assign w_pend1 = g_port[0].w_pend;
    assign w_pend2 = g_port[1].w_pend;

    assign rf_raddr1 = in_rs_addr;
    assign rf_raddr2 = in_rt_addr;
    assign rf_re1    = in_rs_rd && in_valid;
    assign rf_re2    = in_rt_rd && in_valid;

    assign w_stall    = in_valid && (w_pend1 || w_pend2);
    // rst gates readiness so nothing is accepted while the stage is held in reset.
    assign w_in_ready = rst && !w_stall && ((r_state == S_EMPTY) || out_ready) && !flush;
    assign w_xfer     = in_valid && w_in_ready;

    always_comb begin
        w_wreg_eff = in_wreg;
        case (in_cond)
            2'b01:   w_wreg_eff = in_wreg && (w_reg2 != '0);
            2'b10:   w_wreg_eff = in_wreg && (w_reg2 == '0);
            default: w_wreg_eff = in_wreg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_EMPTY;
        end else if (w_xfer) begin
            w_state_next = S_FULL;
        end else if ((r_state == S_FULL) && out_ready) begin
            w_state_next = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= '0;
            r_aluop  <= '0;
            r_alusel <= '0;
            r_reg1   <= '0;
            r_reg2   <= '0;
            r_wd     <= '0;
            r_wreg   <= 1'b0;
        end else if (w_xfer) begin
            r_pc     <= in_pc;
            r_aluop  <= in_aluop;
            r_alusel <= in_alusel;
            r_reg1   <= w_reg1;
            r_reg2   <= w_reg2;
            r_wd     <= in_wd;
            r_wreg   <= w_wreg_eff;
        end else if (flush) begin
            r_wreg   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !flush && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign in_ready   = w_in_ready;
    assign stall      = w_stall;
    assign stall_cnt  = r_stall_cnt;
    assign out_valid  = (r_state == S_FULL);
    assign out_pc     = r_pc;
    assign out_aluop  = r_aluop;
    assign out_alusel = r_alusel;
    assign out_reg1   = r_reg1;
    assign out_reg2   = r_reg2;
    assign out_wd     = r_wd;
    assign out_wreg   = r_wreg;

endmodule
